// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream and register-bus signal bundle for the UART host-command sequencer.
// master = sequencer side, slave = UART/register-bus side.
interface uart_cmd_ctrl_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        reg_rd_ack;

    modport master (
        input  rx_data, rx_valid, tx_ready, reg_rdata, reg_rd_ack,
        output tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, reg_rdata, reg_rd_ack,
        input  tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Host-command sequencer: assembles 10-byte UART command frames, issues one
// register-bus write or read per valid frame and streams back a 10-byte response.
module uart_cmd_ctrl #(
    parameter int unsigned BYTE_TIMEOUT = 100000,
    parameter int unsigned BUS_TIMEOUT  = 255
) (
    input  logic                  HDW_FPGA_100M_CLK,
    input  logic                  HDW_DEVRST_N,
    uart_cmd_ctrl_if.master       bus,
    output logic                  busy,
    output logic [7:0]            frame_err_cnt
);
    localparam int unsigned IDLE_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int unsigned BUS_W  = $clog2(BUS_TIMEOUT + 1);

    localparam logic [7:0] HDR_WR  = 8'h5A;
    localparam logic [7:0] HDR_RD  = 8'h5B;
    localparam logic [7:0] TAIL_WR = 8'hA5;
    localparam logic [7:0] TAIL_RD = 8'hA4;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        COLLECT = 3'd1,
        BUS_WR  = 3'd2,
        BUS_RD  = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t              state_r;
    logic [3:0]          idx_r;
    logic [7:0]          hdr_r;
    logic [31:0]         addr_buf_r;
    logic [31:0]         data_buf_r;
    logic [IDLE_W-1:0]   idle_cnt_r;
    logic [BUS_W-1:0]    bus_cnt_r;
    logic [3:0]          k_r;
    logic [31:0]         resp_data_r;
    logic [7:0]          tx_data_r;
    logic                tx_valid_r;
    logic [31:0]         reg_addr_r;
    logic [31:0]         reg_wdata_r;
    logic                reg_wr_r;
    logic                reg_rd_r;
    logic                busy_r;
    logic [7:0]          err_cnt_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] resp_byte(input logic [3:0] k, input logic [7:0] hdr,
                                             input logic [31:0] a, input logic [31:0] d);
        logic [7:0] b;
        case (k)
            4'd0:    b = hdr;
            4'd1:    b = a[31:24];
            4'd2:    b = a[23:16];
            4'd3:    b = a[15:8];
            4'd4:    b = a[7:0];
            4'd5:    b = d[31:24];
            4'd6:    b = d[23:16];
            4'd7:    b = d[15:8];
            4'd8:    b = d[7:0];
            4'd9:    b = (hdr == HDR_WR) ? TAIL_WR : TAIL_RD;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Frame sequencer: every output is a register updated here.
    always_ff @(posedge HDW_FPGA_100M_CLK or negedge HDW_DEVRST_N) begin
        if (!HDW_DEVRST_N) begin
            state_r     <= HUNT;
            idx_r       <= 4'd0;
            hdr_r       <= 8'h00;
            addr_buf_r  <= 32'h0000_0000;
            data_buf_r  <= 32'h0000_0000;
            idle_cnt_r  <= '0;
            bus_cnt_r   <= '0;
            k_r         <= 4'd0;
            resp_data_r <= 32'h0000_0000;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            reg_addr_r  <= 32'h0000_0000;
            reg_wdata_r <= 32'h0000_0000;
            reg_wr_r    <= 1'b0;
            reg_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
            err_cnt_r   <= 8'h00;
        end else begin
            case (state_r)
                HUNT: begin
                    if (bus.rx_valid && (bus.rx_data == HDR_WR || bus.rx_data == HDR_RD)) begin
                        hdr_r      <= bus.rx_data;
                        idx_r      <= 4'd1;
                        idle_cnt_r <= '0;
                        state_r    <= COLLECT;
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                COLLECT: begin
                    // A byte arriving on the expiry cycle wins over the timeout.
                    if (bus.rx_valid) begin
                        idle_cnt_r <= '0;
                        idx_r      <= idx_r + 4'd1;
                        if (idx_r <= 4'd4) begin
                            addr_buf_r <= {addr_buf_r[23:0], bus.rx_data};
                        end else if (idx_r <= 4'd8) begin
                            data_buf_r <= {data_buf_r[23:0], bus.rx_data};
                        end else if (hdr_r == HDR_WR && bus.rx_data == TAIL_WR) begin
                            reg_addr_r  <= addr_buf_r;
                            reg_wdata_r <= data_buf_r;
                            reg_wr_r    <= 1'b1;
                            state_r     <= BUS_WR;
                        end else if (hdr_r == HDR_RD && bus.rx_data == TAIL_RD) begin
                            reg_addr_r <= addr_buf_r;
                            reg_rd_r   <= 1'b1;
                            state_r    <= BUS_RD;
                        end else begin
                            err_cnt_r <= sat_inc(err_cnt_r);
                            state_r   <= HUNT;
                            busy_r    <= 1'b0;
                        end
                    end else if (idle_cnt_r == IDLE_W'(BYTE_TIMEOUT - 1)) begin
                        err_cnt_r <= sat_inc(err_cnt_r);
                        state_r   <= HUNT;
                        busy_r    <= 1'b0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
                    end
                end
                BUS_WR: begin
                    reg_wr_r    <= 1'b0;
                    resp_data_r <= reg_wdata_r;
                    k_r         <= 4'd0;
                    tx_data_r   <= hdr_r;
                    tx_valid_r  <= 1'b1;
                    state_r     <= RESP;
                end
                BUS_RD: begin
                    // The strobe cycle itself never counts as an ack.
                    if (reg_rd_r) begin
                        reg_rd_r  <= 1'b0;
                        bus_cnt_r <= '0;
                    end else if (bus.reg_rd_ack || bus_cnt_r == BUS_W'(BUS_TIMEOUT - 1)) begin
                        if (bus.reg_rd_ack) begin
                            resp_data_r <= bus.reg_rdata;
                        end else begin
                            resp_data_r <= 32'hDEAD_BEEF;
                            err_cnt_r   <= sat_inc(err_cnt_r);
                        end
                        k_r        <= 4'd0;
                        tx_data_r  <= hdr_r;
                        tx_valid_r <= 1'b1;
                        state_r    <= RESP;
                    end else begin
                        bus_cnt_r <= bus_cnt_r + {{(BUS_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    if (bus.tx_ready) begin
                        if (k_r == 4'd9) begin
                            tx_valid_r <= 1'b0;
                            state_r    <= HUNT;
                            busy_r     <= 1'b0;
                        end else begin
                            k_r       <= k_r + 4'd1;
                            tx_data_r <= resp_byte(k_r + 4'd1, hdr_r, reg_addr_r, resp_data_r);
                        end
                    end else begin
                        tx_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= HUNT;
                    tx_valid_r <= 1'b0;
                    reg_wr_r   <= 1'b0;
                    reg_rd_r   <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_data    = tx_data_r;
    assign bus.tx_valid   = tx_valid_r;
    assign bus.reg_addr   = reg_addr_r;
    assign bus.reg_wdata  = reg_wdata_r;
    assign bus.reg_wr     = reg_wr_r;
    assign bus.reg_rd     = reg_rd_r;
    assign busy           = busy_r;
    assign frame_err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected response bytes are queued as frames
// are sent and compared against bytes captured on the TX handshake.
module tb_uart_cmd_ctrl;
    localparam int BT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [7:0] err_cnt;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.BYTE_TIMEOUT(BT), .BUS_TIMEOUT(255)) dut (
        .HDW_FPGA_100M_CLK (clk),
        .HDW_DEVRST_N      (rst_n),
        .bus               (bus.master),
        .busy              (busy),
        .frame_err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int ack_delay = -1;
    logic [31:0] ack_data = 32'h0;
    logic [7:0] tx_exp[$];
    logic [7:0] tx_obs[$];

    // Capture accepted TX bytes and bus strobes mid-cycle.
    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready) tx_obs.push_back(bus.tx_data);
        if (bus.reg_wr) wr_cnt++;
        if (bus.reg_rd) rd_cnt++;
    end

    // Register-bus read responder.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.reg_rd && ack_delay >= 0) begin
                repeat (ack_delay) @(posedge clk);
                #1;
                bus.reg_rd_ack = 1'b1;
                bus.reg_rdata  = ack_data;
                @(posedge clk);
                #1;
                bus.reg_rd_ack = 1'b0;
                bus.reg_rdata  = 32'h0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [31:0] a,
                              input logic [31:0] d, input logic [7:0] tail);
        logic [79:0] f;
        f = {hdr, a, d, tail};
        for (int i = 9; i >= 0; i--) send_byte(f[i*8 +: 8]);
    endtask

    task automatic push_resp(input logic [7:0] hdr, input logic [31:0] a,
                             input logic [31:0] d, input logic [7:0] tail);
        logic [79:0] f;
        f = {hdr, a, d, tail};
        for (int i = 9; i >= 0; i--) tx_exp.push_back(f[i*8 +: 8]);
    endtask

    task automatic wait_resp(input string name);
        int n;
        int t;
        logic [7:0] e;
        logic [7:0] o;
        n = tx_exp.size();
        t = 0;
        while (tx_obs.size() < n && t < 3000) begin
            idle(1);
            t++;
        end
        checks++;
        if (tx_obs.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d bytes, want %0d", name, tx_obs.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            e = tx_exp.pop_front();
            if (tx_obs.size() > 0) begin
                o = tx_obs.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %02h, want %02h", name, i, o, e);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'h00 ||
            bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0 ||
            bus.reg_addr !== 32'h0 || bus.reg_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: txv=%b busy=%b err=%0d wr=%b rd=%b addr=%h wdata=%h want all 0",
                     bus.tx_valid, busy, err_cnt, bus.reg_wr, bus.reg_rd, bus.reg_addr, bus.reg_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_write();
        int w0;
        w0 = wr_cnt;
        push_resp(8'h5A, 32'h0000_0003, 32'h1234_5678, 8'hA5);
        send_frame(8'h5A, 32'h0000_0003, 32'h1234_5678, 8'hA5);
        checks++;
        if (bus.reg_wr !== 1'b1 || bus.reg_addr !== 32'h3 || bus.reg_wdata !== 32'h1234_5678 ||
            bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_strobe: wr=%b addr=%h wdata=%h txv=%b want 1/00000003/12345678/0",
                     bus.reg_wr, bus.reg_addr, bus.reg_wdata, bus.tx_valid);
        end
        idle(1);
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL write_latency: txv=%b wr=%b want 1/0", bus.tx_valid, bus.reg_wr);
        end
        wait_resp("write_resp");
        checks++;
        if (wr_cnt - w0 !== 1 || err_cnt !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL write_after: pulses=%0d err=%0d busy=%b want 1/0/0", wr_cnt - w0, err_cnt, busy);
        end
    endtask

    task automatic test_read_ack();
        int r0;
        r0 = rd_cnt;
        ack_delay = 3;
        ack_data  = 32'h1234_5678;
        push_resp(8'h5B, 32'h0000_0003, 32'h1234_5678, 8'hA4);
        send_frame(8'h5B, 32'h0000_0003, 32'h0000_0000, 8'hA4);
        checks++;
        if (bus.reg_rd !== 1'b1 || bus.reg_addr !== 32'h3) begin
            errors++;
            $display("FAIL read_strobe: rd=%b addr=%h want 1/00000003", bus.reg_rd, bus.reg_addr);
        end
        wait_resp("read_resp");
        checks++;
        if (rd_cnt - r0 !== 1 || bus.reg_wdata !== 32'h1234_5678 || err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL read_after: pulses=%0d wdata=%h err=%0d want 1/12345678/0",
                     rd_cnt - r0, bus.reg_wdata, err_cnt);
        end
    endtask

    task automatic test_read_timeout();
        ack_delay = -1;
        push_resp(8'h5B, 32'h0000_0004, 32'hDEAD_BEEF, 8'hA4);
        send_frame(8'h5B, 32'h0000_0004, 32'h0000_0000, 8'hA4);
        wait_resp("rdto_resp");
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rdto_errcnt: got %0d want 1", err_cnt);
        end
    endtask

    task automatic test_garbage_and_bad_tail();
        int w0;
        w0 = wr_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        push_resp(8'h5A, 32'h0000_0004, 32'h8765_4321, 8'hA5);
        send_frame(8'h5A, 32'h0000_0004, 32'h8765_4321, 8'hA5);
        wait_resp("garbage_resp");
        checks++;
        if (wr_cnt - w0 !== 1 || err_cnt !== 8'd1 || bus.reg_wdata !== 32'h8765_4321) begin
            errors++;
            $display("FAIL garbage_after: pulses=%0d err=%0d wdata=%h want 1/1/87654321",
                     wr_cnt - w0, err_cnt, bus.reg_wdata);
        end
        w0 = wr_cnt;
        send_frame(8'h5A, 32'h0000_0009, 32'hAAAA_5555, 8'hA4);
        idle(20);
        checks++;
        if (wr_cnt - w0 !== 0 || tx_obs.size() !== 0 || err_cnt !== 8'd2 || busy !== 1'b0 ||
            bus.reg_addr !== 32'h4) begin
            errors++;
            $display("FAIL bad_tail: pulses=%0d txbytes=%0d err=%0d busy=%b addr=%h want 0/0/2/0/00000004",
                     wr_cnt - w0, tx_obs.size(), err_cnt, busy, bus.reg_addr);
        end
    endtask

    task automatic test_byte_timeout();
        send_byte(8'h5B);
        send_byte(8'h00);
        send_byte(8'h00);
        idle(BT + 1);
        checks++;
        if (err_cnt !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL byte_timeout: err=%0d busy=%b want 3/0", err_cnt, busy);
        end
        ack_delay = 1;
        ack_data  = 32'hCAFE_F00D;
        push_resp(8'h5B, 32'h0000_0000, 32'hCAFE_F00D, 8'hA4);
        send_frame(8'h5B, 32'h0000_0000, 32'h0000_0000, 8'hA4);
        wait_resp("after_to_resp");
        checks++;
        if (err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL after_to_errcnt: got %0d want 3", err_cnt);
        end
    endtask

    task automatic test_stall_and_reset();
        int t;
        logic [7:0] held;
        bus.tx_ready = 1'b1;
        send_frame(8'h5A, 32'h1122_3344, 32'h5566_7788, 8'hA5);
        t = 0;
        while (tx_obs.size() < 3 && t < 100) begin
            idle(1);
            t++;
        end
        bus.tx_ready = 1'b0;
        checks++;
        if (tx_obs.size() != 3) begin
            errors++;
            $display("FAIL stall_setup: got %0d bytes want 3", tx_obs.size());
        end
        held = 8'h33;
        for (int i = 0; i < 50; i++) begin
            idle(1);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== held) begin
                checks++;
                errors++;
                $display("FAIL stall_hold: cyc %0d txv=%b data=%02h want 1/%02h", i, bus.tx_valid, bus.tx_data, held);
                break;
            end
        end
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== held || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_end: txv=%b data=%02h busy=%b want 1/%02h/1", bus.tx_valid, bus.tx_data, busy, held);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_midresp: txv=%b busy=%b err=%0d want 0/0/0", bus.tx_valid, busy, err_cnt);
        end
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        bus.tx_ready = 1'b1;
        idle(3);
        checks++;
        if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: txv=%b busy=%b want 0/0", bus.tx_valid, busy);
        end
    endtask

    initial begin
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.tx_ready   = 1'b1;
        bus.reg_rdata  = 32'h0;
        bus.reg_rd_ack = 1'b0;
        test_reset();
        test_write();
        test_read_ack();
        test_read_timeout();
        test_garbage_and_bad_tail();
        test_byte_timeout();
        test_stall_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Host-command sequencer between the debug UART byte stream and the internal register bus. Assembles 10-byte command frames: 0x5A = write, 0x5B = read, 4 address bytes, 4 data bytes, then a tail byte (0xA5 for write, 0xA4 for read). It validates each frame and issues exactly one register-bus write or read. It then returns a 10-byte response frame through the UART TX byte interface.

Parameters:
BYTE_TIMEOUT, 100000, max idle cycles between bytes of one frame (1 ms at 100 MHz) before the frame is abandoned
BUS_TIMEOUT, 255, max cycles to wait for reg_rd_ack after reg_rd

Ports:
HDW_FPGA_100M_CLK  in  1  system clock, all logic on rising edge
HDW_DEVRST_N  in  1  asynchronous active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  UART TX can take a byte
reg_addr  out  32  register bus address
reg_wdata  out  32  register bus write data
reg_wr  out  1  one-cycle write strobe
reg_rd  out  1  one-cycle read strobe
reg_rdata  in  32  read data, valid with reg_rd_ack
reg_rd_ack  in  1  read completion strobe
busy  out  1  high whenever state != HUNT
frame_err_cnt  out  8  saturating count of bad, timed-out or bus-timeout frames

Behaviour:
- Reset (async assert, sync release): state=HUNT; all outputs 0, including reg_addr, reg_wdata and frame_err_cnt. Assertion mid-frame or mid-response aborts immediately; tx_valid drops with reset.
- Byte order: big-endian. Byte1 is addr[31:24] ... byte4 is addr[7:0]; byte5 is data[31:24] ... byte8 is data[7:0].
- State HUNT: on rx_valid with 0x5A or 0x5B, store the header and go to COLLECT (idx=1). Other bytes are dropped silently and not counted.
- State COLLECT: each rx_valid stores the byte at idx and increments idx.
  - The idle counter clears on each byte. If it reaches BYTE_TIMEOUT: frame_err_cnt+1, go to HUNT, no response.
  - On byte 9 (tail): a tail that mismatches the header (0x5A needs 0xA5, 0x5B needs 0xA4) gives frame_err_cnt+1, HUNT, no response.
  - A matching write goes to BUS_WR; a matching read goes to BUS_RD.
- State BUS_WR: the cycle after the tail-accepting edge, reg_wr=1 for exactly one cycle, with reg_addr/reg_wdata already stable. Then go to RESP. The response is an echo of the command: 5A, addr[4], data[4], A5.
- State BUS_RD: the cycle after the tail edge, reg_rd=1 for one cycle. Then wait.
  - reg_rd_ack is honoured from the cycle after reg_rd onward; reg_rdata is captured on the ack cycle.
  - If no ack within BUS_TIMEOUT cycles: data=32'hDEADBEEF, frame_err_cnt+1.
  - Response: 5B, addr[4], data[4], A4.
- State RESP: tx_valid=1 with tx_data = response byte k. k advances only on a cycle with tx_valid && tx_ready. After byte 9 is accepted, tx_valid=0 the next cycle and state=HUNT.
- reg_addr/reg_wdata hold their values until overwritten by the next valid frame. reg_wdata is not changed by read frames.
- rx_valid in BUS_WR, BUS_RD or RESP: the byte is dropped and not counted. The host must wait for the response.
- rx_valid in the same cycle as an idle-counter expiry: the byte is accepted and the timeout is ignored.
- frame_err_cnt saturates at 255; it never wraps.
- Latency (write, tx_ready tied 1): tail edge → reg_wr at +1 cycle → first tx_valid at +2 cycles.

Test Plan:
1. Write frame 5A 00 00 00 03 12 34 56 78 A5 → single reg_wr pulse with addr=0x00000003, wdata=0x12345678; response 5A 00 00 00 03 12 34 56 78 A5; frame_err_cnt=0.
2. Read frame 5B 00 00 00 03 00×4 A4 with the bus acking 3 cycles after reg_rd carrying rdata=0x12345678 → one reg_rd pulse, addr=3; response 5B 00 00 00 03 12 34 56 78 A4.
3. Read of addr 4 with ack never asserted → after 255 cycles the response is 5B 00 00 00 04 DE AD BE EF A4 and frame_err_cnt=1.
4. Garbage 11 22 followed by a valid write 5A..A5 to addr 4 with data 0x87654321 → garbage ignored, one reg_wr pulse, frame_err_cnt unchanged. Separately, a 5A frame ending in A4 → no bus strobe, no TX, frame_err_cnt+1.
5. Send 5B 00 00, then idle for BYTE_TIMEOUT+1 cycles, then send a full valid read of addr 0 → the partial frame is counted as an error (frame_err_cnt+1) and the following frame is answered normally.
6. Hold tx_ready=0 for 50 cycles during byte 3 of a response, then assert HDW_DEVRST_N=0 mid-response → tx_valid stays high and tx_data stable while stalled; on reset tx_valid, busy and frame_err_cnt go to 0 immediately.
